freq_meas_sched: RTL and testbench
==================================

# freq_meas_sched

Measurement scheduler for the phase-meter frequency path. It sequences one equal-precision (reciprocal) frequency measurement after another on `sig_in`:

- an auto-range prescan on enable,
- a gate opened and closed on signal edges,
- a handshake with the shared 64/32 divider.

It produces a rounded frequency in Hz and picks each next gate length from the previous result.

## Interface
- `CLK_F`, 50_000_000: system clock frequency in Hz; also the numerator scale.
- `PRESCAN_CYC`, 50_000_000: prescan window length in clk cycles.
- `TIMEOUT_CYC`, 100_000_000: maximum clk cycles without a signal edge in ARM/GATE.
- `clk`  in  1  system clock; all logic on rising edge.
- `rst_n`  in  1  reset, asynchronous, active-low.
- `en`  in  1  level; high = measure continuously.
- `sig_in`  in  1  asynchronous measured signal.
- `gate`  out  1  high while gate open; reset 0.
- `div_req`  out  1  divider request; reset 0.
- `div_num`  out  64  numerator, stable while `div_req`=1; reset 0.
- `div_den`  out  32  denominator, stable while `div_req`=1; reset 0.
- `div_ack`  in  1  one-cycle pulse; `div_quot` valid in the same cycle.
- `div_quot`  in  32  quotient.
- `fre`  out  32  last frequency in Hz; reset 0.
- `fre_valid`  out  1  one-cycle pulse when `fre` updates; reset 0.
- `range_idx`  out  3  current range 0..4; reset 0.
- `err_timeout`  out  1  sticky; cleared when a measurement completes normally; reset 0.
- `busy`  out  1  state != IDLE; reset 0.

## Operation
- `sig_in` passes through a 2-FF synchronizer plus rising-edge detect giving `edge` (1 clk pulse, latency 3 clk). Valid for `sig_in` ≤ CLK_F/4.
- Range table: edge count or Hz, then range_idx, then gate periods N.
  - <10: idx 0, N=1
  - <100: idx 1, N=10
  - <1000: idx 2, N=100
  - <10000: idx 3, N=1000
  - else: idx 4, N=10000
- States: IDLE, PRESCAN, ARM, GATE, DIV, REPORT.
- IDLE → PRESCAN on `en`=1.
- PRESCAN:
  - count `edge` for exactly PRESCAN_CYC cycles (32-bit, saturating).
  - At the end, set `range_idx` from the count, then go to ARM.
- ARM:
  - wait for `edge`.
  - On `edge`: `gate`←1, Ns←0, Nx←0, go to GATE.
- GATE:
  - Ns increments every cycle.
  - Nx increments on each `edge`.
  - On the `edge` where Nx+1==N: `gate`←0, latch Nx=N and Ns+1, go to DIV.
  - Ns is therefore the clk-cycle distance between the opening and closing edges.
- DIV:
  - `div_num` = CLK_F*Nx + (Ns>>1), which gives round-to-nearest.
  - `div_den` = Ns.
  - `div_req`=1 until the `div_ack` cycle, then 0.
- REPORT (1 cycle):
  - `fre`←captured quotient, `fre_valid`=1, `err_timeout`←0.
  - `range_idx` is re-selected from the new `fre` using the Hz column.
  - Go to ARM if `en`, else IDLE.
- Timeout: in ARM or GATE, if TIMEOUT_CYC cycles pass without `edge`:
  - `gate`←0, `fre`←0, `fre_valid` pulse, `err_timeout`←1, `range_idx`←0.
  - Go to PRESCAN if `en`, else IDLE.
- `en` falling:
  - in PRESCAN, ARM or GATE: abort to IDLE next cycle, `gate`←0, no `fre_valid`.
  - in DIV: `div_req` held until `div_ack`, quotient discarded, go to IDLE.
- `en` rising again always restarts with PRESCAN.
- Width rules:
  - Ns is 32-bit; Ns cannot overflow because timeout bounds it.
  - `div_num` is computed in 64 bits.
  - Quotient > 2^32-1 cannot occur, since Ns≥4 for the N=1 case.

## Timing
- Gate opens and closes 3 clk after the true `sig_in` edges. The constant skew cancels in Ns.
- ARM→GATE transition is on the `edge` cycle. A closing `edge` moves GATE→DIV with `div_req` high on the next cycle.
- `fre_valid` is asserted 1 cycle after `div_ack`.
- The next ARM begins the cycle after REPORT. The closing edge is not reused as the next opening edge.
- `edge` coincident with the timeout terminal count: the edge wins and the timeout counter resets.

## Structure
- Shared package `freq_meas_pkg`:
  - state enum
  - range thresholds (10/100/1000/10000)
  - gate-period table indexed by range_idx
- One sub-module `sig_sync_edge` (2-FF synchronizer + rising-edge pulse), reused by the phase path.
- The divider is external and shared.

## Test plan
All scenarios use CLK_F=1000, PRESCAN_CYC=1000, TIMEOUT_CYC=2000, and a divider model that acks 5 clk after req.

- **Nominal range 1:** `sig_in` period 50 clk, `en`=1.
  - Prescan counts 20 edges, so range_idx=1 and N=10.
  - Ns=500, `div_num`=10250, `fre`=20.
  - Then repeated 20 updates without a new prescan.
- **Range 0:** period 400 clk gives prescan count 2, range_idx=0, N=1, Ns=400, `fre`=3 (2.5 rounds up).
- **Timeout:** stop `sig_in` while in GATE.
  - After 2000 idle cycles: `fre`=0, `fre_valid` pulse, `err_timeout`=1, PRESCAN re-entered.
  - Restoring a period-50 signal gives `fre`=20 and clears `err_timeout`.
- **Handshake hold:** with the divider stalling `div_ack` 100 cycles, `div_req`, `div_num` and `div_den` stay constant and exactly one `fre_valid` follows the ack.
- **Abort:**
  - `en`→0 mid-GATE: `gate` is 0 next cycle and no `fre_valid`.
  - `en`→0 in DIV: waits for ack, no `fre_valid`, ends in IDLE.
- **Reset mid-operation:** `rst_n` pulsed low during GATE sets all outputs to reset values immediately; the next `en` restarts from PRESCAN.

Source files
------------

// File: rtl/freq_meas_pkg.sv
// rtl/freq_meas_pkg.sv - shared types and range tables for the reciprocal frequency path
package freq_meas_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_PRESCAN,
    ST_ARM,
    ST_GATE,
    ST_DIV,
    ST_REPORT
  } state_t;

  // Upper bounds (exclusive) of ranges 0..3; anything larger falls into range 4
  localparam logic [3:0][31:0] RANGE_THR  = {32'd10000, 32'd1000, 32'd100, 32'd10};
  localparam logic [4:0][31:0] GATE_N_TAB = {32'd10000, 32'd1000, 32'd100, 32'd10, 32'd1};

  function automatic logic [2:0] range_sel(input logic [31:0] v);
    logic [2:0] r;
    r = 3'd4;
    for (int i = 3; i >= 0; i--) begin
      if (v < RANGE_THR[i]) r = 3'(i);
    end
    return r;
  endfunction

  function automatic logic [31:0] gate_periods(input logic [2:0] idx);
    return (idx > 3'd4) ? GATE_N_TAB[4] : GATE_N_TAB[idx];
  endfunction

endpackage

// File: rtl/sig_sync_edge.sv
// rtl/sig_sync_edge.sv - 2-FF synchronizer with a one-cycle rising-edge pulse
module sig_sync_edge (
  input  logic clk,
  input  logic rst_n,
  input  logic d,
  output logic pulse
);

  logic [2:0] sh;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) sh <= '0;
    else        sh <= {sh[1:0], d};
  end

  assign pulse = sh[1] & ~sh[2];

endmodule

// File: rtl/freq_meas_sched.sv
// rtl/freq_meas_sched.sv - equal-precision frequency measurement scheduler with auto-range
module freq_meas_sched
  import freq_meas_pkg::*;
#(
  parameter int unsigned CLK_F       = 50_000_000,
  parameter int unsigned PRESCAN_CYC = 50_000_000,
  parameter int unsigned TIMEOUT_CYC = 100_000_000
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        en,
  input  logic        sig_in,
  output logic        gate,
  output logic        div_req,
  output logic [63:0] div_num,
  output logic [31:0] div_den,
  input  logic        div_ack,
  input  logic [31:0] div_quot,
  output logic [31:0] fre,
  output logic        fre_valid,
  output logic [2:0]  range_idx,
  output logic        err_timeout,
  output logic        busy
);

  state_t      state, state_nxt;
  logic        sig_edge;
  logic [31:0] pre_cnt, edge_cnt, to_cnt, ns, nx;
  logic        abort_r;

  logic [31:0] gate_n, edge_cnt_inc, ns_cls;
  logic        pre_last, to_last, close_hit, discard;

  sig_sync_edge u_sync (
    .clk   (clk),
    .rst_n (rst_n),
    .d     (sig_in),
    .pulse (sig_edge)
  );

  always_comb begin
    gate_n       = gate_periods(range_idx);
    edge_cnt_inc = (sig_edge && edge_cnt != '1) ? edge_cnt + 32'd1 : edge_cnt;
    ns_cls       = ns + 32'd1;
    pre_last     = (pre_cnt == PRESCAN_CYC - 1);
    to_last      = (to_cnt == TIMEOUT_CYC - 1);
    close_hit    = (nx + 32'd1 == gate_n);
    discard      = abort_r | ~en;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= ST_IDLE;
    else        state <= state_nxt;
  end

  // Disable has priority over everything except an in-flight divide
  always_comb begin
    state_nxt = state;
    case (state)
      ST_IDLE:    if (en) state_nxt = ST_PRESCAN;
      ST_PRESCAN: if (!en) state_nxt = ST_IDLE;
                  else if (pre_last) state_nxt = ST_ARM;
      ST_ARM:     if (!en) state_nxt = ST_IDLE;
                  else if (sig_edge) state_nxt = ST_GATE;
                  else if (to_last) state_nxt = ST_PRESCAN;
      ST_GATE:    if (!en) state_nxt = ST_IDLE;
                  else if (sig_edge && close_hit) state_nxt = ST_DIV;
                  else if (!sig_edge && to_last) state_nxt = ST_PRESCAN;
      ST_DIV:     if (div_ack) state_nxt = discard ? ST_IDLE : ST_REPORT;
      ST_REPORT:  state_nxt = en ? ST_ARM : ST_IDLE;
      default:    state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      gate        <= 1'b0;
      div_req     <= 1'b0;
      div_num     <= '0;
      div_den     <= '0;
      fre         <= '0;
      fre_valid   <= 1'b0;
      range_idx   <= '0;
      err_timeout <= 1'b0;
      pre_cnt     <= '0;
      edge_cnt    <= '0;
      to_cnt      <= '0;
      ns          <= '0;
      nx          <= '0;
      abort_r     <= 1'b0;
    end else begin
      fre_valid <= 1'b0;
      if (state != ST_PRESCAN) begin
        pre_cnt  <= '0;
        edge_cnt <= '0;
      end
      if (state != ST_ARM && state != ST_GATE) to_cnt <= '0;

      case (state)
        ST_PRESCAN: if (en) begin
          pre_cnt  <= pre_cnt + 32'd1;
          edge_cnt <= edge_cnt_inc;
          if (pre_last) range_idx <= range_sel(edge_cnt_inc);
        end
        ST_ARM, ST_GATE: begin
          if (!en) begin
            gate <= 1'b0;
          end else if (sig_edge) begin
            to_cnt <= '0;
            if (state == ST_ARM) begin
              gate <= 1'b1;
              ns   <= '0;
              nx   <= '0;
            end else begin
              ns <= ns_cls;
              nx <= nx + 32'd1;
              if (close_hit) begin
                gate    <= 1'b0;
                div_req <= 1'b1;
                div_den <= ns_cls;
                // Adding half the denominator turns the divider's truncation into rounding
                div_num <= 64'(CLK_F) * 64'(gate_n) + 64'(ns_cls >> 1);
              end
            end
          end else if (to_last) begin
            gate        <= 1'b0;
            fre         <= '0;
            fre_valid   <= 1'b1;
            err_timeout <= 1'b1;
            range_idx   <= '0;
          end else begin
            to_cnt <= to_cnt + 32'd1;
            if (state == ST_GATE) ns <= ns_cls;
          end
        end
        ST_DIV: begin
          if (!en) abort_r <= 1'b1;
          if (div_ack) begin
            div_req <= 1'b0;
            abort_r <= 1'b0;
            if (!discard) begin
              fre         <= div_quot;
              fre_valid   <= 1'b1;
              err_timeout <= 1'b0;
              range_idx   <= range_sel(div_quot);
            end
          end
        end
        default: ;
      endcase
    end
  end

  assign busy = (state != ST_IDLE);

endmodule

// File: tb/tb_freq_meas_sched.sv
// tb/tb_freq_meas_sched.sv - scoreboard bench for freq_meas_sched
module tb_freq_meas_sched;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        en = 1'b0;
  logic        sig_in = 1'b0;
  logic        div_ack = 1'b0;
  logic [31:0] div_quot = '0;
  logic        gate, div_req, fre_valid, err_timeout, busy;
  logic [63:0] div_num;
  logic [31:0] div_den, fre;
  logic [2:0]  range_idx;

  freq_meas_sched #(
    .CLK_F       (1000),
    .PRESCAN_CYC (1000),
    .TIMEOUT_CYC (2000)
  ) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .en          (en),
    .sig_in      (sig_in),
    .gate        (gate),
    .div_req     (div_req),
    .div_num     (div_num),
    .div_den     (div_den),
    .div_ack     (div_ack),
    .div_quot    (div_quot),
    .fre         (fre),
    .fre_valid   (fre_valid),
    .range_idx   (range_idx),
    .err_timeout (err_timeout),
    .busy        (busy)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int checks = 0;
  int errors = 0;
  int sig_period = 0;
  int ack_delay = 5;
  int ack_cyc = 0;
  int fv_cyc = 0;
  int fv_prev = 0;
  int fv_count = 0;

  typedef struct { int unsigned fre; bit err; int unsigned rng; } res_t;
  typedef struct { longint unsigned num; int unsigned den; } divx_t;
  res_t  res_q[$];
  divx_t div_q[$];

  function automatic res_t mk_res(int unsigned f, bit e, int unsigned r);
    res_t x;
    x.fre = f; x.err = e; x.rng = r;
    return x;
  endfunction

  // Expected divider operands for a clean square wave of the given period and gate length
  function automatic divx_t mk_div(int unsigned per, int unsigned n);
    divx_t x;
    x.den = per * n;
    x.num = 64'(1000 * n) + 64'(x.den / 2);
    return x;
  endfunction

  function automatic int unsigned exp_fre(int unsigned per, int unsigned n);
    divx_t x;
    x = mk_div(per, n);
    return int'(x.num / 64'(x.den));
  endfunction

  initial begin
    forever begin
      if (sig_period == 0) begin
        sig_in = 1'b0;
        @(posedge clk); #3;
      end else begin
        sig_in = 1'b1;
        repeat (sig_period / 2) @(posedge clk);
        #3;
        sig_in = 1'b0;
        repeat (sig_period - sig_period / 2) @(posedge clk);
        #3;
      end
    end
  end

  // Divider model: checks operands, holds them for ack_delay cycles, then acks
  initial begin
    longint unsigned cap_num;
    int unsigned     cap_den;
    bit              stable;
    divx_t           e;
    forever begin
      @(posedge clk); #1;
      if (rst_n && div_req === 1'b1) begin
        cap_num = div_num;
        cap_den = div_den;
        checks++;
        if (div_q.size() == 0) begin
          errors++;
          $display("FAIL div_operands unexpected request num=%0d den=%0d", div_num, div_den);
        end else begin
          e = div_q.pop_front();
          if (div_num !== e.num || div_den !== e.den) begin
            errors++;
            $display("FAIL div_operands got num=%0d den=%0d want num=%0d den=%0d",
                     div_num, div_den, e.num, e.den);
          end
        end
        stable = 1'b1;
        repeat (ack_delay) begin
          @(posedge clk); #1;
          if (div_req !== 1'b1 || div_num !== cap_num || div_den !== cap_den) stable = 1'b0;
        end
        div_ack  = 1'b1;
        div_quot = (cap_den == 0) ? 32'd0 : 32'(cap_num / 64'(cap_den));
        ack_cyc  = cyc;
        @(posedge clk); #1;
        div_ack = 1'b0;
        checks++;
        if (!stable || div_req !== 1'b0) begin
          errors++;
          $display("FAIL div_hold got stable=%0b req_after_ack=%0b want stable=1 req_after_ack=0",
                   stable, div_req);
        end
      end
    end
  end

  // Result monitor: every fre_valid must match the next scoreboard entry
  initial begin
    res_t e;
    forever begin
      @(negedge clk);
      if (rst_n && fre_valid === 1'b1) begin
        fv_prev = fv_cyc;
        fv_cyc  = cyc;
        fv_count++;
        checks++;
        if (res_q.size() == 0) begin
          errors++;
          $display("FAIL fre_valid unexpected pulse fre=%0d want no pulse", fre);
        end else begin
          e = res_q.pop_front();
          if (fre !== e.fre || err_timeout !== e.err || range_idx !== 3'(e.rng)) begin
            errors++;
            $display("FAIL result got fre=%0d err=%0b rng=%0d want fre=%0d err=%0b rng=%0d",
                     fre, err_timeout, range_idx, e.fre, e.err, e.rng);
          end
          if (!e.err) begin
            checks++;
            if (cyc != ack_cyc + 1) begin
              errors++;
              $display("FAIL fre_latency got %0d want %0d cycles after ack", cyc - ack_cyc, 1);
            end
          end
        end
      end
    end
  end

  // sel: 0 gate high, 1 scoreboards drained, 2 div_req high, 3 div_req low
  task automatic wait_for(input int sel, input int budget, output bit to);
    bit hit;
    to = 1'b1;
    for (int i = 0; i < budget; i++) begin
      @(negedge clk);
      case (sel)
        0:       hit = (gate === 1'b1);
        1:       hit = (res_q.size() == 0 && div_q.size() == 0);
        2:       hit = (div_req === 1'b1);
        default: hit = (div_req === 1'b0);
      endcase
      if (hit) begin
        to = 1'b0;
        break;
      end
    end
  endtask

  task automatic push_meas(input int unsigned per, input int unsigned n, input int unsigned rng);
    div_q.push_back(mk_div(per, n));
    res_q.push_back(mk_res(exp_fre(per, n), 1'b0, rng));
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    en    = 1'b0;
    repeat (3) @(negedge clk);
    checks++;
    if ({gate, div_req, fre_valid, err_timeout, busy} !== 5'b0) begin
      errors++;
      $display("FAIL reset_flags got %b want 00000", {gate, div_req, fre_valid, err_timeout, busy});
    end
    checks++;
    if (div_num !== 64'd0 || div_den !== 32'd0) begin
      errors++;
      $display("FAIL reset_div got num=%0d den=%0d want 0 0", div_num, div_den);
    end
    checks++;
    if (fre !== 32'd0 || range_idx !== 3'd0) begin
      errors++;
      $display("FAIL reset_fre got fre=%0d rng=%0d want 0 0", fre, range_idx);
    end
    rst_n = 1'b1;
    repeat (2) @(negedge clk);
  endtask

  task automatic test_range1();
    bit to;
    sig_period = 50;
    repeat (60) @(negedge clk);
    en = 1'b1;
    for (int i = 0; i < 3; i++) push_meas(50, 10, 1);
    wait_for(0, 1200, to);
    checks++;
    if (to || range_idx !== 3'd1) begin
      errors++;
      $display("FAIL range1_prescan got timeout=%0b rng=%0d want timeout=0 rng=1", to, range_idx);
    end
    wait_for(1, 2500, to);
    checks++;
    if (to) begin
      errors++;
      $display("FAIL range1_results got %0d pending want 0", res_q.size());
    end
    checks++;
    if (fv_cyc - fv_prev >= 1000 || fv_cyc - fv_prev < 500) begin
      errors++;
      $display("FAIL range1_no_prescan got gap=%0d want 500..999", fv_cyc - fv_prev);
    end
    en = 1'b0;
    repeat (5) @(negedge clk);
    checks++;
    if (busy !== 1'b0) begin
      errors++;
      $display("FAIL range1_idle got busy=%0b want 0", busy);
    end
  endtask

  task automatic test_range0();
    bit to;
    sig_period = 400;
    repeat (450) @(negedge clk);
    en = 1'b1;
    push_meas(400, 1, 0);
    push_meas(400, 1, 0);
    wait_for(1, 5000, to);
    checks++;
    if (to) begin
      errors++;
      $display("FAIL range0_results got %0d pending want 0", res_q.size());
    end
    en = 1'b0;
    repeat (5) @(negedge clk);
  endtask

  task automatic test_timeout();
    bit to;
    sig_period = 50;
    repeat (450) @(negedge clk);
    en = 1'b1;
    push_meas(50, 10, 1);
    wait_for(1, 2500, to);
    wait_for(0, 200, to);
    checks++;
    if (to) begin
      errors++;
      $display("FAIL timeout_gate_open got gate=%0b want 1", gate);
    end
    repeat (10) @(negedge clk);
    sig_period = 0;
    res_q.push_back(mk_res(0, 1'b1, 0));
    wait_for(1, 2600, to);
    checks++;
    if (to || gate !== 1'b0 || busy !== 1'b1) begin
      errors++;
      $display("FAIL timeout_event got timeout=%0b gate=%0b busy=%0b want 0 0 1", to, gate, busy);
    end
    sig_period = 50;
    push_meas(50, 10, 1);
    wait_for(1, 2500, to);
    checks++;
    if (to || fv_cyc - fv_prev <= 1000) begin
      errors++;
      $display("FAIL timeout_recover got timeout=%0b gap=%0d want 0 >1000", to, fv_cyc - fv_prev);
    end
    en = 1'b0;
    repeat (5) @(negedge clk);
  endtask

  task automatic test_handshake();
    bit to;
    int c0;
    c0 = fv_count;
    ack_delay = 100;
    en = 1'b1;
    push_meas(50, 10, 1);
    wait_for(1, 2000, to);
    en = 1'b0;
    repeat (5) @(negedge clk);
    checks++;
    if (to || fv_count - c0 != 1) begin
      errors++;
      $display("FAIL handshake_single got timeout=%0b pulses=%0d want 0 1", to, fv_count - c0);
    end
    ack_delay = 5;
  endtask

  task automatic test_abort_gate();
    bit to;
    int c0;
    en = 1'b1;
    wait_for(0, 1200, to);
    repeat (100) @(negedge clk);
    checks++;
    if (to || gate !== 1'b1) begin
      errors++;
      $display("FAIL abort_gate_open got timeout=%0b gate=%0b want 0 1", to, gate);
    end
    c0 = fv_count;
    en = 1'b0;
    @(negedge clk);
    checks++;
    if (gate !== 1'b0 || busy !== 1'b0) begin
      errors++;
      $display("FAIL abort_gate_stop got gate=%0b busy=%0b want 0 0", gate, busy);
    end
    repeat (600) @(negedge clk);
    checks++;
    if (fv_count != c0) begin
      errors++;
      $display("FAIL abort_gate_quiet got %0d pulses want 0", fv_count - c0);
    end
  endtask

  task automatic test_abort_div();
    bit to;
    int c0;
    ack_delay = 100;
    c0 = fv_count;
    en = 1'b1;
    div_q.push_back(mk_div(50, 10));
    wait_for(2, 1800, to);
    checks++;
    if (to) begin
      errors++;
      $display("FAIL abort_div_req got div_req=%0b want 1", div_req);
    end
    repeat (10) @(negedge clk);
    en = 1'b0;
    wait_for(3, 200, to);
    repeat (3) @(negedge clk);
    checks++;
    if (to || busy !== 1'b0 || fv_count != c0) begin
      errors++;
      $display("FAIL abort_div_end got timeout=%0b busy=%0b pulses=%0d want 0 0 0",
               to, busy, fv_count - c0);
    end
    checks++;
    if (fre !== 32'd20 || err_timeout !== 1'b0) begin
      errors++;
      $display("FAIL abort_div_keep got fre=%0d err=%0b want 20 0", fre, err_timeout);
    end
    ack_delay = 5;
  endtask

  task automatic test_reset_mid();
    bit to;
    int t0;
    en = 1'b1;
    wait_for(0, 1200, to);
    repeat (50) @(negedge clk);
    rst_n = 1'b0;
    #1;
    checks++;
    if (to || {gate, div_req, fre_valid, err_timeout, busy} !== 5'b0 || fre !== 32'd0 ||
        range_idx !== 3'd0 || div_num !== 64'd0 || div_den !== 32'd0) begin
      errors++;
      $display("FAIL reset_mid got flags=%b fre=%0d rng=%0d want 00000 0 0",
               {gate, div_req, fre_valid, err_timeout, busy}, fre, range_idx);
    end
    repeat (3) @(negedge clk);
    push_meas(50, 10, 1);
    t0 = cyc;
    rst_n = 1'b1;
    wait_for(1, 2500, to);
    checks++;
    if (to || fv_cyc - t0 <= 1000) begin
      errors++;
      $display("FAIL reset_restart got timeout=%0b delay=%0d want 0 >1000", to, fv_cyc - t0);
    end
    en = 1'b0;
    repeat (5) @(negedge clk);
  endtask

  initial begin
    test_reset();
    test_range1();
    test_range0();
    test_timeout();
    test_handshake();
    test_abort_gate();
    test_abort_div();
    test_reset_mid();
    checks++;
    if (res_q.size() != 0 || div_q.size() != 0) begin
      errors++;
      $display("FAIL scoreboard_drain got res=%0d div=%0d pending want 0 0", res_q.size(), div_q.size());
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
